message_responder: RTL and testbench

Memory-side endpoint of the processor message network. It accepts request messages {addr, requester proc ID}, reads a single-port synchronous BRAM, and returns response messages {data, requester proc ID} to the network.
- Requests are buffered on input.
- Responses are buffered against network backpressure.
- A credit scheme ensures BRAM reads are issued only when the response buffer is guaranteed room, so nothing is ever dropped.

---
 rtl/msg_pkg.sv | 41 ++++
 rtl/msg_fifo.sv | 48 ++++
 rtl/message_responder.sv | 125 ++++++++++++
 tb/tb_message_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_pkg.sv
// rtl/msg_pkg.sv - message field layout shared by the responder and the requester-side router
package msg_pkg;

  localparam int DEF_PROC_BITS = 4;
  localparam int DEF_DATA_SIZE = 32;

  typedef struct packed {
    logic [DEF_DATA_SIZE-1:0] addr;
    logic [DEF_PROC_BITS-1:0] proc_id;
  } req_msg_t;

  typedef struct packed {
    logic [DEF_DATA_SIZE-1:0] data;
    logic [DEF_PROC_BITS-1:0] proc_id;
  } resp_msg_t;

  function automatic req_msg_t pack_req(input logic [DEF_DATA_SIZE-1:0] addr,
                                        input logic [DEF_PROC_BITS-1:0] proc_id);
    req_msg_t m;
    m.addr    = addr;
    m.proc_id = proc_id;
    return m;
  endfunction

  function automatic resp_msg_t pack_resp(input logic [DEF_DATA_SIZE-1:0] data,
                                          input logic [DEF_PROC_BITS-1:0] proc_id);
    resp_msg_t m;
    m.data    = data;
    m.proc_id = proc_id;
    return m;
  endfunction

  function automatic logic [DEF_PROC_BITS-1:0] req_proc_id(input req_msg_t m);
    return m.proc_id;
  endfunction

  function automatic logic [DEF_DATA_SIZE-1:0] resp_data(input resp_msg_t m);
    return m.data;
  endfunction

endpackage

// File: rtl/msg_fifo.sv
// rtl/msg_fifo.sv - synchronous FIFO with extra-bit pointers; a push while full is refused
module msg_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the pre-edge state, so a pop cannot make room for a same-edge push.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/message_responder.sv
// rtl/message_responder.sv - memory-side endpoint: request FIFO, credited BRAM read issue, response FIFO
module message_responder
  import msg_pkg::*;
#(
  parameter int PROC_BITS    = DEF_PROC_BITS,
  parameter int DATA_SIZE    = DEF_DATA_SIZE,
  parameter int ADDR_BITS    = 10,
  parameter int READ_LATENCY = 2,
  parameter int REQ_DEPTH    = 4,
  parameter int RESP_DEPTH   = 4
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [DATA_SIZE+PROC_BITS-1:0] req_msg_in,
  input  logic                           req_valid_in,
  output logic                           req_ready_out,
  output logic                           mem_en_out,
  output logic [ADDR_BITS-1:0]           mem_addr_out,
  input  logic [DATA_SIZE-1:0]           mem_data_in,
  output logic [DATA_SIZE+PROC_BITS-1:0] resp_msg_out,
  output logic                           resp_valid_out,
  input  logic                           resp_ready_in
);

  localparam int MW = DATA_SIZE + PROC_BITS;
  localparam int CW = $clog2(RESP_DEPTH) + 1;

  logic [MW-1:0]                 req_head;
  logic                          req_full;
  logic                          req_empty;
  logic [$clog2(REQ_DEPTH):0]    req_count;
  logic                          resp_full;
  logic                          resp_empty;
  logic [$clog2(RESP_DEPTH):0]   resp_count;
  logic                          issue;
  logic                          resp_pop;
  logic [CW-1:0]                 credits;
  logic [READ_LATENCY-1:0]       pipe_valid;
  logic [PROC_BITS-1:0]          pipe_id [READ_LATENCY];
  logic                          unused_addr_bits;

  assign unused_addr_bits = ^req_head[MW-1:PROC_BITS+ADDR_BITS];

  msg_fifo #(.WIDTH(MW), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (req_valid_in),
    .push_data (req_msg_in),
    .pop       (issue),
    .head      (req_head),
    .full      (req_full),
    .empty     (req_empty),
    .count     (req_count)
  );

  assign req_ready_out = !req_full;

  // Credits count every read that will land in the response FIFO, so a return always has room.
  assign issue    = !req_empty && (credits < CW'(RESP_DEPTH));
  assign resp_pop = !resp_empty && resp_ready_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      credits <= '0;
    end else begin
      case ({issue, resp_pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_en_out   <= 1'b0;
      mem_addr_out <= '0;
    end else begin
      mem_en_out <= issue;
      if (issue) mem_addr_out <= req_head[PROC_BITS +: ADDR_BITS];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pipe_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_id[i] <= '0;
    end else begin
      pipe_valid[0] <= issue;
      pipe_id[0]    <= req_head[PROC_BITS-1:0];
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
      end
    end
  end

  msg_fifo #(.WIDTH(MW), .DEPTH(RESP_DEPTH)) u_resp_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (pipe_valid[READ_LATENCY-1]),
    .push_data ({mem_data_in, pipe_id[READ_LATENCY-1]}),
    .pop       (resp_pop),
    .head      (resp_msg_out),
    .full      (resp_full),
    .empty     (resp_empty),
    .count     (resp_count)
  );

  assign resp_valid_out = !resp_empty;

`ifndef SYNTHESIS
  always @(posedge clk_in) begin
    if (!rst_in) begin
      assert (!(pipe_valid[READ_LATENCY-1] && resp_full))
        else $error("response returned into a full response FIFO");
      assert (int'(credits) == $countones(pipe_valid) + int'(resp_count))
        else $error("credit counter out of step with reads in flight");
      assert (int'(req_count) <= REQ_DEPTH)
        else $error("request FIFO occupancy out of range");
    end
  end
`endif

endmodule

// File: tb/tb_message_responder.sv
// tb/tb_message_responder.sv - directed bench with a queue-based ordering model of the responder
module tb_message_responder;
  import msg_pkg::*;

  logic        clk;
  logic        rst_in;
  logic [35:0] req_msg_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        mem_en_out;
  logic [9:0]  mem_addr_out;
  logic [31:0] mem_data_in;
  logic [35:0] resp_msg_out;
  logic        resp_valid_out;
  logic        resp_ready_in;

  message_responder dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .req_msg_in     (req_msg_in),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .mem_en_out     (mem_en_out),
    .mem_addr_out   (mem_addr_out),
    .mem_data_in    (mem_data_in),
    .resp_msg_out   (resp_msg_out),
    .resp_valid_out (resp_valid_out),
    .resp_ready_in  (resp_ready_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM: address registered by the DUT is read one edge later, data held for the capture edge.
  logic [31:0] bram [1024];
  logic [31:0] bram_q = 32'h0;
  always @(posedge clk) if (mem_en_out) bram_q <= bram[mem_addr_out];
  assign mem_data_in = bram_q;

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int issued = 0;
  int popped = 0;
  int run = 0;
  int max_run = 0;
  logic [35:0] exp_q[$];
  logic [35:0] log_q[$];

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: responses are the BRAM words of accepted requests, in accept order; reads never outrun credits.
  always @(negedge clk) begin
    if (rst_in) begin
      exp_q.delete();
      issued = 0;
      popped = 0;
      run = 0;
    end else begin
      if (mem_en_out) begin
        issued++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (resp_valid_out) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL resp_spurious: got %h want none", resp_msg_out);
        end else if (resp_msg_out !== exp_q[0]) begin
          bad++;
          $display("FAIL resp_order: got %h want %h", resp_msg_out, exp_q[0]);
        end
        if (resp_ready_in) begin
          log_q.push_back(resp_msg_out);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          popped++;
        end
      end
      total++;
      if (issued - popped > 4) begin
        bad++;
        $display("FAIL credit_bound: got %0d outstanding want <= 4", issued - popped);
      end
      if (req_valid_in && req_ready_out)
        exp_q.push_back(pack_resp(bram[req_msg_in[13:4]], req_msg_in[3:0]));
    end
  end

  int last_acc = 0;

  task automatic send(input logic [31:0] a, input logic [3:0] id);
    int n = 0;
    bit done = 1'b0;
    req_msg_in   = pack_req(a, id);
    req_valid_in = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      done = req_ready_out;
      @(posedge clk);
      #2;
      n++;
    end
    req_valid_in = 1'b0;
    last_acc = edge_n;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept want accept for addr %h", a);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
  endtask

  int base;
  int iss0;
  int first_acc;

  initial begin
    rst_in = 1'b1;
    req_valid_in = 1'b0;
    req_msg_in = '0;
    resp_ready_in = 1'b1;
    for (int i = 0; i < 1024; i++) bram[i] = 32'hC0DE_0000 + i;
    bram[16] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) bram[i] = 32'h100 + i;
    bram[5] = 32'h5555A5A5;
    for (int i = 0; i < 8; i++) bram[32 + i] = 32'h2000 + i;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_ready", req_ready_out, 1);
    chk("rst_resp_valid", resp_valid_out, 0);
    chk("rst_mem_en", mem_en_out, 0);
    chk("rst_mem_addr", mem_addr_out, 0);
    chk("rst_resp_msg", resp_msg_out, 0);
    rst_in = 1'b0;
    @(posedge clk);
    #2;

    // single request, latency 3 edges, one cycle wide
    send(32'h10, 4'h3);
    @(negedge clk); chk("single_en_early", mem_en_out, 0);
    @(negedge clk); chk("single_en", mem_en_out, 1);
    chk("single_addr", mem_addr_out, 10'h010);
    chk("single_valid_t1", resp_valid_out, 0);
    @(negedge clk); chk("single_valid_t2", resp_valid_out, 0);
    @(negedge clk); chk("single_valid_t3", resp_valid_out, 1);
    chk("single_msg", resp_msg_out, {32'hDEADBEEF, 4'h3});
    @(negedge clk); chk("single_valid_t4", resp_valid_out, 0);
    @(posedge clk); #2;

    // burst of four, full rate
    base = log_q.size();
    iss0 = issued;
    max_run = 0;
    send(32'h0, 4'h1);
    first_acc = last_acc;
    for (int i = 1; i < 4; i++) send(i, 4'(i + 1));
    chk("burst_accept_span", last_acc - first_acc, 3);
    wait_drain();
    chk("burst_reads", issued - iss0, 4);
    chk("burst_run", max_run, 4);
    chk("burst_count", log_q.size() - base, 4);
    for (int i = 0; i < 4; i++)
      chk("burst_msg", log_q[base + i], {32'h100 + 32'(i), 4'(i + 1)});

    // backpressure: four reads, four queued, then stall
    resp_ready_in = 1'b0;
    base = log_q.size();
    iss0 = issued;
    for (int i = 0; i < 8; i++) send(32'h20 + 32'(i), 4'(i));
    repeat (6) @(posedge clk);
    #2;
    chk("bp_reads", issued - iss0, 4);
    chk("bp_req_ready", req_ready_out, 0);
    chk("bp_resp_valid", resp_valid_out, 1);
    chk("bp_head", resp_msg_out, {32'h2000, 4'h0});

    // full request FIFO: pop and new request at the same edge refuses the push
    resp_ready_in = 1'b1;
    req_msg_in = pack_req(32'h3FF, 4'hE);
    req_valid_in = 1'b1;
    @(negedge clk); chk("sim_ready_a", req_ready_out, 0);
    @(posedge clk); #2;
    resp_ready_in = 1'b0;
    @(negedge clk); chk("sim_ready_b", req_ready_out, 0);
    chk("sim_en_b", mem_en_out, 0);
    @(posedge clk); #2;
    req_valid_in = 1'b0;
    @(negedge clk); chk("sim_ready_c", req_ready_out, 1);
    chk("sim_en_c", mem_en_out, 1);
    repeat (6) @(posedge clk);
    #2;
    chk("credit_limit", issued - popped, 4);
    resp_ready_in = 1'b1;
    wait_drain();
    chk("bp_count", log_q.size() - base, 8);
    for (int i = 0; i < 8; i++)
      chk("bp_msg", log_q[base + i], {32'h2000 + 32'(i), 4'(i)});

    // reset with two reads in flight
    send(32'h40, 4'h6);
    send(32'h41, 4'h7);
    @(posedge clk); #2;
    base = log_q.size();
    rst_in = 1'b1;
    #1;
    chk("mid_rst_en", mem_en_out, 0);
    chk("mid_rst_addr", mem_addr_out, 0);
    chk("mid_rst_valid", resp_valid_out, 0);
    chk("mid_rst_msg", resp_msg_out, 0);
    chk("mid_rst_ready", req_ready_out, 1);
    @(posedge clk);
    @(posedge clk); #2;
    rst_in = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("mid_rst_no_resp", log_q.size() - base, 0);

    // upper address bits alias onto the BRAM index
    send(32'hFFFF_F405, 4'hF);
    @(negedge clk);
    @(negedge clk); chk("alias_en", mem_en_out, 1);
    chk("alias_addr", mem_addr_out, 10'h005);
    wait_drain();
    chk("alias_count", log_q.size() - base, 1);
    chk("alias_msg", log_q[log_q.size() - 1], {32'h5555A5A5, 4'hF});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
